// File: rtl/mmu_tlb_regs_pkg.sv
// Shared MMU definitions: CP0 register selects, TLB op codes, FSM states,
// field positions of the MMU registers and the TLB entry layout.
package mmu_tlb_regs_pkg;

    typedef enum logic [3:0] {
        MMU_REG_NONE     = 4'd0,
        MMU_REG_INDEX    = 4'd1,
        MMU_REG_RANDOM   = 4'd2,
        MMU_REG_ENTRYLO0 = 4'd3,
        MMU_REG_ENTRYLO1 = 4'd4,
        MMU_REG_CTX      = 4'd5,
        MMU_REG_PAGEMASK = 4'd6,
        MMU_REG_WIRED    = 4'd7,
        MMU_REG_ENTRYHI  = 4'd8
    } mmu_reg_t;

    typedef enum logic [1:0] {
        TLB_OP_TLBR  = 2'd0,
        TLB_OP_TLBWI = 2'd1,
        TLB_OP_TLBWR = 2'd2,
        TLB_OP_TLBP  = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } tlb_state_t;

    localparam int VPN2_LO    = 13;
    localparam int VPN2_W     = 19;
    localparam int ASID_W     = 8;
    localparam int LO_W       = 26;
    localparam int PTEBASE_LO = 23;
    localparam int PTEBASE_W  = 9;
    localparam int BADVPN2_LO = 4;
    localparam int INDEX_P    = 31;

    // EntryLo images are kept without their G bit; G is stored once per entry.
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [LO_W-2:0]   lo0;
        logic [LO_W-2:0]   lo1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational comparison of one TLB entry against a VPN2/ASID pair.
// Shared between the TLBP probe and the address translation path.
module tlb_match
    import mmu_tlb_regs_pkg::*;
(
    input  logic [VPN2_W-1:0] entry_vpn2,
    input  logic [ASID_W-1:0] entry_asid,
    input  logic              entry_g,
    input  logic [VPN2_W-1:0] vpn2,
    input  logic [ASID_W-1:0] asid,
    output logic              hit
);

    assign hit = (entry_vpn2 == vpn2) && (entry_g || (entry_asid == asid));

endmodule

// File: rtl/mmu_tlb_regs.sv
// MMU-visible CP0 registers and the TLB entry array: MTC0/MFC0 access,
// TLBR/TLBWI/TLBWR and a sequential one-entry-per-cycle TLBP probe.
module mmu_tlb_regs
    import mmu_tlb_regs_pkg::*;
#(
    parameter int NENTRIES = 16,
    parameter int IDXW     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mmu_reg,
    input  logic [31:0] mmu_dataIn,
    output logic [31:0] mmu_dataOut,
    input  logic        readMMUReg,
    input  logic        writeMMUReg,
    input  logic        tlbReq,
    input  logic [1:0]  tlbOp,
    output logic        tlbBusy,
    output logic        tlbDone,
    input  logic        excTlb,
    input  logic [31:0] badVAddr
);

    localparam logic [IDXW-1:0] LAST = IDXW'(NENTRIES - 1);

    tlb_state_t           state;
    logic [IDXW-1:0]      ptr;
    logic                 index_p;
    logic [IDXW-1:0]      index_idx;
    logic [IDXW-1:0]      random;
    logic [IDXW-1:0]      wired;
    logic [LO_W-1:0]      entrylo0;
    logic [LO_W-1:0]      entrylo1;
    logic [PTEBASE_W-1:0] ctx_ptebase;
    logic [VPN2_W-1:0]    ctx_badvpn2;
    logic [VPN2_W-1:0]    hi_vpn2;
    logic [ASID_W-1:0]    hi_asid;
    tlb_entry_t           entries [NENTRIES];

    mmu_reg_t   sel;
    tlb_op_t    op;
    logic       wr_en;
    logic       probe_hit;
    tlb_entry_t probe_entry;
    tlb_entry_t rd_entry;
    tlb_entry_t new_entry;

    assign sel   = mmu_reg_t'(mmu_reg);
    assign op    = tlb_op_t'(tlbOp);
    assign wr_en = writeMMUReg && (state == ST_IDLE);

    assign probe_entry = entries[ptr];
    assign rd_entry    = entries[index_idx];
    assign new_entry   = '{vpn2: hi_vpn2,
                           asid: hi_asid,
                           g:    entrylo0[0] & entrylo1[0],
                           lo0:  entrylo0[LO_W-1:1],
                           lo1:  entrylo1[LO_W-1:1]};

    tlb_match u_probe_match (
        .entry_vpn2 (probe_entry.vpn2),
        .entry_asid (probe_entry.asid),
        .entry_g    (probe_entry.g),
        .vpn2       (hi_vpn2),
        .asid       (hi_asid),
        .hit        (probe_hit)
    );

    // MFC0 has no side effects, so the read strobe only matters upstream.
    logic unused_inputs;
    assign unused_inputs = ^{readMMUReg, badVAddr[VPN2_LO-1:0]};

    always_comb begin
        mmu_dataOut = '0;
        case (sel)
            MMU_REG_INDEX: begin
                mmu_dataOut[INDEX_P]    = index_p;
                mmu_dataOut[IDXW-1:0]   = index_idx;
            end
            MMU_REG_RANDOM:   mmu_dataOut[IDXW-1:0] = random;
            MMU_REG_ENTRYLO0: mmu_dataOut[LO_W-1:0] = entrylo0;
            MMU_REG_ENTRYLO1: mmu_dataOut[LO_W-1:0] = entrylo1;
            MMU_REG_CTX: begin
                mmu_dataOut[31:PTEBASE_LO]         = ctx_ptebase;
                mmu_dataOut[PTEBASE_LO-1:BADVPN2_LO] = ctx_badvpn2;
            end
            MMU_REG_WIRED:    mmu_dataOut[IDXW-1:0] = wired;
            MMU_REG_ENTRYHI: begin
                mmu_dataOut[31:VPN2_LO]  = hi_vpn2;
                mmu_dataOut[ASID_W-1:0]  = hi_asid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            index_p     <= 1'b0;
            index_idx   <= '0;
            random      <= LAST;
            wired       <= '0;
            entrylo0    <= '0;
            entrylo1    <= '0;
            ctx_ptebase <= '0;
            ctx_badvpn2 <= '0;
            hi_vpn2     <= '0;
            hi_asid     <= '0;
            tlbBusy     <= 1'b0;
            tlbDone     <= 1'b0;
            // NOTE: the entry array is deliberately reset so that every entry
            // starts invalid; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (wr_en && sel == MMU_REG_WIRED) begin
                random <= LAST;
            end else if (random == wired || random == '0) begin
                random <= LAST;
            end else begin
                random <= random - IDXW'(1);
            end

            // NOTE: the last non-blocking assignment to a register in this
            // block wins, so MTC0, then TLB ops, then excTlb encodes priority.
            if (wr_en) begin
                case (sel)
                    MMU_REG_INDEX:    index_idx   <= mmu_dataIn[IDXW-1:0];
                    MMU_REG_ENTRYLO0: entrylo0    <= mmu_dataIn[LO_W-1:0];
                    MMU_REG_ENTRYLO1: entrylo1    <= mmu_dataIn[LO_W-1:0];
                    MMU_REG_CTX:      ctx_ptebase <= mmu_dataIn[31:PTEBASE_LO];
                    MMU_REG_WIRED:    wired       <= mmu_dataIn[IDXW-1:0];
                    MMU_REG_ENTRYHI: begin
                        hi_vpn2 <= mmu_dataIn[31:VPN2_LO];
                        hi_asid <= mmu_dataIn[ASID_W-1:0];
                    end
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (tlbReq) begin
                        tlbBusy <= 1'b1;
                        case (op)
                            TLB_OP_TLBR: begin
                                hi_vpn2  <= rd_entry.vpn2;
                                hi_asid  <= rd_entry.asid;
                                entrylo0 <= {rd_entry.lo0, rd_entry.g};
                                entrylo1 <= {rd_entry.lo1, rd_entry.g};
                                state    <= ST_DONE;
                            end
                            TLB_OP_TLBWI: begin
                                entries[index_idx] <= new_entry;
                                state              <= ST_DONE;
                            end
                            TLB_OP_TLBWR: begin
                                entries[random] <= new_entry;
                                state           <= ST_DONE;
                            end
                            TLB_OP_TLBP: begin
                                ptr   <= '0;
                                state <= ST_PROBE;
                            end
                        endcase
                    end
                end
                ST_PROBE: begin
                    if (probe_hit || ptr == LAST) begin
                        index_p   <= ~probe_hit;
                        index_idx <= probe_hit ? ptr : '0;
                        tlbBusy   <= 1'b0;
                        tlbDone   <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        ptr <= ptr + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    // Reads/writes spend a busy cycle here before the done pulse.
                    if (tlbDone) begin
                        tlbDone <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tlbBusy <= 1'b0;
                        tlbDone <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (excTlb) begin
                hi_vpn2     <= badVAddr[31:VPN2_LO];
                ctx_badvpn2 <= badVAddr[31:VPN2_LO];
            end
        end
    end

endmodule
